// File: rtl/press_classifier.sv
// Gesture classifier for a debounced button: short, double and long press ticks.
// Define PRESS_CLASSIFIER_AUTO_REPEAT_EN to emit repeat_tick periodically while held long.
module press_classifier #(
  parameter int LONG_TICKS   = 50_000_000,
  parameter int DCLICK_TICKS = 25_000_000,
  parameter int REPEAT_TICKS = 10_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic short_tick,
  output logic double_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_e;

  localparam int MAX_TICKS = (LONG_TICKS > DCLICK_TICKS)
                             ? ((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS)
                             : ((DCLICK_TICKS > REPEAT_TICKS) ? DCLICK_TICKS : REPEAT_TICKS);

  // Terminal counts must be representable without wrap.
  if (longint'(MAX_TICKS) >= (longint'(1) << CNT_W)) begin : g_cnt_w_too_small
    $error("press_classifier: CNT_W too small for tick parameters");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;
`ifdef PRESS_CLASSIFIER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic             repeat_q, repeat_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef PRESS_CLASSIFIER_AUTO_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (db) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (!db) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT2: begin
        if (db) begin
          state_d  = PRESS2;
          double_d = 1'b1;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS2: begin
        // Second press never escalates to a long press.
        if (!db) state_d = IDLE;
      end
      LONG_HELD: begin
`ifdef PRESS_CLASSIFIER_AUTO_REPEAT_EN
        if (!db) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        if (!db) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

`ifdef PRESS_CLASSIFIER_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) repeat_q <= 1'b0;
    else       repeat_q <= repeat_d;
  end
  assign repeat_tick = repeat_q;
`else
  assign repeat_tick = 1'b0;
`endif

  assign short_tick  = short_q;
  assign double_tick = double_q;
  assign long_tick   = long_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: golden event-index table per gesture, scoreboard queue,
// plus hand sequences for asynchronous reset mid-press and on a live tick.
module tb_press_classifier;

  localparam int LONG_T   = 10;
  localparam int DCLICK_T = 6;
  localparam int REPEAT_T = 4;
  localparam int CW       = 4;
`ifdef PRESS_CLASSIFIER_AUTO_REPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic clk, reset, db;
  logic short_tick, double_tick, long_tick, repeat_tick, busy;

  press_classifier #(
    .LONG_TICKS  (LONG_T),
    .DCLICK_TICKS(DCLICK_T),
    .REPEAT_TICKS(REPEAT_T),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db         (db),
    .short_tick (short_tick),
    .double_tick(double_tick),
    .long_tick  (long_tick),
    .repeat_tick(repeat_tick),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // db pattern: h1 high, l1 low, h2 high, l2 low. Event fields are edge indices
  // (edge 0 = first driven cycle), -1 = never. Busy high over [bf0,bt0] and [bf1,bt1].
  typedef struct packed {
    int h1; int l1; int h2; int l2;
    int sh0; int sh1; int dbl; int lng;
    int bf0; int bt0; int bf1; int bt1;
    bit rep;
  } scen_t;

  scen_t      tbl [7];
  logic [4:0] sb_q [$];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [4:0] outs();
    return {busy, repeat_tick, long_tick, double_tick, short_tick};
  endfunction

  function automatic logic [4:0] exp_at(input scen_t s, input int k);
    logic sh, dl, lg, rp, bz;
    sh = (k == s.sh0) || (k == s.sh1);
    dl = (k == s.dbl);
    lg = (k == s.lng);
    rp = AR_EN && s.rep && (k > s.lng) && ((k - s.lng) % REPEAT_T == 0) && (k < s.h1);
    bz = (k >= s.bf0 && k <= s.bt0) || (k >= s.bf1 && k <= s.bt1);
    return {bz, rp, lg, dl, sh};
  endfunction

  task automatic check(input string tag, input int k, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {busy,rep,long,dbl,short}=%b expected %b", tag, k, got, exp);
    end
  endtask

  // Drive one cycle of db away from the edge, sample #1 after the edge, end on negedge.
  task automatic step(input string tag, input int k, input logic d, input logic [4:0] exp);
    logic [4:0] e;
    db = d;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s cycle %0d: scoreboard empty", tag, k);
    end else begin
      e = sb_q.pop_front();
      check(tag, k, outs(), e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    db    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, outs(), 5'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_scen(input int idx, input bit rst_first);
    scen_t s;
    int    total;
    logic  d;
    s = tbl[idx];
    if (rst_first) do_reset();
    total = s.h1 + s.l1 + s.h2 + s.l2;
    for (int k = 0; k < total; k++) begin
      d = (k < s.h1) || ((k >= s.h1 + s.l1) && (k < s.h1 + s.l1 + s.h2));
      step($sformatf("scen%0d", idx), k, d, exp_at(s, k));
    end
  endtask

  initial begin
    reset = 1'b1;
    db    = 1'b0;
    //          h1  l1 h2 l2  sh0 sh1 dbl lng  bf0 bt0 bf1 bt1 rep
    tbl[0] = '{  3, 10, 0, 0,   9, -1, -1, -1,   0,  8, -1, -1, 1'b0}; // short
    tbl[1] = '{  3,  4, 5, 6,  -1, -1,  7, -1,   0, 11, -1, -1, 1'b0}; // double
    tbl[2] = '{ 10, 10, 0, 0,  16, -1, -1, -1,   0, 15, -1, -1, 1'b0}; // long-1 -> short
    tbl[3] = '{ 11,  5, 0, 0,  -1, -1, -1, 10,   0, 10, -1, -1, 1'b0}; // long exact
    tbl[4] = '{  2,  6, 3, 5,  -1, -1,  8, -1,   0, 10, -1, -1, 1'b0}; // last window cycle
    tbl[5] = '{  2,  7, 3,10,   8, 18, -1, -1,   0,  7,  9, 17, 1'b0}; // window expired
    tbl[6] = '{ 23,  5, 0, 0,  -1, -1, -1, 10,   0, 22, -1, -1, 1'b1}; // auto-repeat hold

    for (int i = 0; i < 7; i++) run_scen(i, 1'b1);

    // Async reset 5 edges into PRESS1, released with db still high.
    do_reset();
    for (int k = 0; k < 5; k++) step("press1_pre", k, 1'b1, 5'b10000);
    reset = 1'b1;
    #1;
    check("async_rst_press1", 0, outs(), 5'b0);
    @(posedge clk);
    #1;
    check("rst_dominates_db", 0, outs(), 5'b0);
    @(negedge clk);
    reset = 1'b0;
    run_scen(3, 1'b0);

    // Async reset while long_tick is high clears it at once.
    do_reset();
    for (int k = 0; k < 11; k++)
      step("long_pre", k, 1'b1, (k == 10) ? 5'b10100 : 5'b10000);
    reset = 1'b1;
    #1;
    check("async_rst_long", 0, outs(), 5'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step("post_rst_idle", k, 1'b0, 5'b0);

    if (sb_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
